// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder slice.
//   DATA_W_DEF / ADDR_W_DEF : default word width and word-address width
//   CNT_W                   : latency counter width (covers LATENCY 1..15)
//   dm_state_t              : responder FSM states
package dm_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } dm_state_t;

endpackage

// File: rtl/dm_array.sv
// dm_array: synchronous single-port word storage, 2^ADDR_W x DATA_W.
//   clk   : clock, all activity on the rising edge
//   we    : write enable, mem[addr] <= wdata
//   re    : read enable, rdata <= mem[addr]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds its value while re is low
// Contents and rdata are never reset so the array maps onto block RAM.
module dm_array
  import dm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory side of the DM request/done handshake with a
// programmable access latency.
//   clk   : clock
//   rst   : asynchronous reset, active low
//   ena   : request valid, held high by the initiator until done
//   wea   : 1 = write, 0 = read (sampled with ena)
//   addra : word address (sampled with ena)
//   dina  : write data (sampled with ena)
//   douta : read data of the most recent completed read
//   done  : one-cycle completion pulse
//   busy  : high from acceptance until the FSM is back in IDLE
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              done,
  output logic              busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dm_responder: LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dm_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              latch_en;
  logic              wea_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              arr_we, arr_re;
  logic [DATA_W-1:0] arr_rdata;

  dm_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (arr_rdata)
  );

  // The array read register has no reset, so douta is forced to zero until
  // the first read after reset has completed. arr_rdata only changes on a
  // read, which keeps douta stable across writes, idle and HOLD.
  assign douta = rd_valid_q ? arr_rdata : '0;
  assign done  = done_q;
  assign busy  = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Request capture: once accepted, later changes on the inputs are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wea_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (latch_en) begin
      wea_q  <= wea;
      addr_q <= addra;
      data_q <= dina;
    end
  end

  // The array is only enabled on the WAIT->DONE edge. In DONE a still-high
  // ena is the same, already served request, so the FSM parks in HOLD until
  // ena drops instead of re-executing it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    latch_en   = 1'b0;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ena) begin
          latch_en = 1'b1;
          cnt_d    = CNT_LOAD;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          arr_we  = wea_q;
          arr_re  = ~wea_q;
          done_d  = 1'b1;
          state_d = S_DONE;
          if (!wea_q) begin
            rd_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (ena) begin
          state_d = S_HOLD;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!ena) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: self-checking bench for dm_responder. Two instances
// (LATENCY=2 and LATENCY=1) share clock, reset and data inputs; sel picks
// which one receives ena and whose outputs are checked.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [6:0]  addra;
  logic [31:0] dina;
  logic        sel;

  logic        ena2, ena1;
  logic [31:0] douta2, douta1, douta;
  logic        done2, done1, done;
  logic        busy2, busy1, busy;

  int checks;
  int errors;

  logic [31:0] modelMem [2][128];
  bit          written  [2][128];
  logic [31:0] modelDout [2];

  typedef struct {
    bit          abortFirst;
    bit          s;
    bit          w;
    logic [6:0]  a;
    logic [31:0] d;
    int          hold;
    int          scramble;
    logic [31:0] expDout;
  } vec_t;

  vec_t vecs [15];

  assign ena2  = ena & ~sel;
  assign ena1  = ena & sel;
  assign douta = sel ? douta1 : douta2;
  assign done  = sel ? done1  : done2;
  assign busy  = sel ? busy1  : busy2;

  dm_responder #(.DATA_W(32), .ADDR_W(7), .LATENCY(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena2),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta2),
    .done  (done2),
    .busy  (busy2)
  );

  dm_responder #(.DATA_W(32), .ADDR_W(7), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena1),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta1),
    .done  (done1),
    .busy  (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete request: accept, latency window, done pulse, optional
  // hold with ena still high, then ena low and return to idle.
  task automatic applyStimulus(input bit w, input logic [6:0] a, input logic [31:0] d,
                               input int hold, input int scramble,
                               input logic [31:0] expDout, input string tag);
    int lat;
    lat   = sel ? 1 : 2;
    ena   = 1'b1;
    wea   = w;
    addra = a;
    dina  = d;
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " busy@accept"}, 32'(busy), 32'd1);
    checkOutput({tag, " done@accept"}, 32'(done), 32'd0);
    if (scramble == 1) begin
      wea   = 1'($urandom);
      addra = 7'($urandom);
      dina  = $urandom;
    end else if (scramble == 2) begin
      addra = 7'h20;
      dina  = 32'h99999999;
    end
    for (int j = 1; j < lat; j++) begin
      @(posedge clk); @(negedge clk);
      checkOutput({tag, " done@wait"}, 32'(done), 32'd0);
      checkOutput({tag, " busy@wait"}, 32'(busy), 32'd1);
    end
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " done@pulse"}, 32'(done), 32'd1);
    checkOutput({tag, " busy@pulse"}, 32'(busy), 32'd1);
    checkOutput({tag, " douta@pulse"}, douta, expDout);
    if (w) begin
      modelMem[sel][a] = d;
      written[sel][a]  = 1'b1;
    end else begin
      modelDout[sel] = modelMem[sel][a];
    end
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); @(negedge clk);
      checkOutput({tag, " done@hold"}, 32'(done), 32'd0);
      checkOutput({tag, " busy@hold"}, 32'(busy), 32'd1);
    end
    ena = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " done@idle"}, 32'(done), 32'd0);
    checkOutput({tag, " busy@idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " douta@idle"}, douta, modelDout[sel]);
  endtask

  // Write to 0x7F aborted by reset during WAIT: no done, no memory update.
  task automatic abortSequence();
    ena   = 1'b1;
    wea   = 1'b1;
    addra = 7'h7F;
    dina  = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    checkOutput("abort busy@accept", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort busy@reset", 32'(busy), 32'd0);
    checkOutput("abort done@reset", 32'(done), 32'd0);
    checkOutput("abort douta@reset", douta, 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("abort done@held", 32'(done), 32'd0);
      checkOutput("abort busy@held", 32'(busy), 32'd0);
    end
    ena = 1'b0;
    rst = 1'b1;
    modelDout[0] = '0;
    modelDout[1] = '0;
    @(negedge clk);
    checkOutput("abort done@release", 32'(done), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int s = 0; s < 2; s++) begin
      modelDout[s] = '0;
      for (int i = 0; i < 128; i++) begin
        written[s][i]  = 1'b0;
        modelMem[s][i] = '0;
      end
    end

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 7'h05, 32'hDEADBEEF, 3,  0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'h05, 32'h00000000, 0,  0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'h05, 32'h00000000, 10, 0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 7'h05, 32'h01020304, 0,  0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 7'h20, 32'h22222222, 0,  0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 7'h10, 32'h11111111, 0,  2, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 7'h10, 32'h00000000, 0,  0, 32'h11111111};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'h20, 32'h00000000, 0,  0, 32'h22222222};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 7'h7F, 32'h12345678, 0,  0, 32'h22222222};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 7'h7F, 32'h00000000, 0,  0, 32'h12345678};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 7'h00, 32'hA5A5A5A5, 0,  0, 32'h00000000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 7'h00, 32'h00000000, 0,  0, 32'hA5A5A5A5};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 7'h7F, 32'h5A5A5A5A, 0,  0, 32'hA5A5A5A5};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 7'h7F, 32'h00000000, 0,  0, 32'h5A5A5A5A};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 7'h00, 32'h00000000, 2,  0, 32'hA5A5A5A5};

    // Reset with a write request already presented on ena.
    sel   = 1'b0;
    rst   = 1'b0;
    ena   = 1'b1;
    wea   = 1'b1;
    addra = 7'h05;
    dina  = 32'hDEADBEEF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset douta", douta, 32'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].s != sel) begin
        sel = vecs[i].s;
        @(negedge clk);
      end
      if (vecs[i].abortFirst) begin
        abortSequence();
      end
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold,
                    vecs[i].scramble, vecs[i].expDout, $sformatf("vec%0d", i));
    end

    // Randomized traffic against the reference model, both latencies.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int n = 0; n < 40; n++) begin
        bit          w;
        logic [6:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        a = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
        w = 1'($urandom_range(0, 1));
        if (!w && !written[s][a]) w = 1'b1;
        d   = $urandom;
        exp = w ? modelDout[s] : modelMem[s][a];
        applyStimulus(w, a, d, $urandom_range(0, 3), 1, exp,
                      $sformatf("rnd%0d_%0d", s, n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Responder (memory side) of the processor's data-memory request/done handshake: 2^ADDR_W x DATA_W word storage with a programmable access latency.
- Accepts one read or write request, holds it for LATENCY cycles, completes the access, then pulses done.
- Sits opposite the processor's DM initiator port inside the top-level wrapper. Drop-in replacement for the single-cycle DM model, used to exercise processor stall logic.

Parameters:
- DATA_W, 32, word width of dina/douta.
- ADDR_W, 7, word-address width; depth = 2^ADDR_W.
- LATENCY, 2, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- ena  input  1  request valid, level; initiator holds it high until done.
- wea  input  1  1 = write, 0 = read; sampled with ena.
- addra  input  ADDR_W  word address; sampled with ena.
- dina  input  DATA_W  write data; sampled with ena.
- douta  output  DATA_W  read data; registered.
- done  output  1  one-cycle completion pulse; registered.
- busy  output  1  high from the acceptance edge until return to IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, done=0, busy=0, douta=0, latency counter=0.
  - Storage contents are NOT reset.
  - Reset asserted mid-access aborts it: no write occurs and done never pulses.
- States: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - On an edge where ena=1, latch wea/addra/dina.
  - Load counter with LATENCY-1, set busy=1, go to WAIT.
  - ena=0 in IDLE: nothing changes.
- WAIT:
  - Inputs are ignored; changes to addra/dina/wea have no effect after acceptance.
  - Counter!=0: decrement.
  - Counter==0: perform the access on this edge and go to DONE with done=1.
    - Write: mem[addr] <= data; douta unchanged.
    - Read: douta <= mem[addr].
- Latency: acceptance at edge E0 puts done high in the cycle after edge E0+LATENCY, for exactly one cycle.
  - LATENCY=1: done high in the cycle after the edge following acceptance.
- DONE (one cycle only): done=0 on exit.
  - ena=0: go to IDLE, busy=0.
  - ena=1: go to HOLD, busy stays 1. This treats the held ena as the same, completed request.
- HOLD: stay until ena is sampled 0, then go to IDLE with busy=0. No re-execution of the held request.
- A new request needs ena low for at least one sampled edge after done. Minimum spacing between accepted requests is LATENCY+2 edges.
- douta holds its last read value across writes, idle periods and HOLD.
- Read after write to the same address returns the new data. There is no read-during-write hazard, because only one access is in flight.
- Address has no out-of-range case: all 2^ADDR_W values are valid.
- LATENCY outside 1..15 is a compile-time error.

Decomposition:
- Package dm_pkg:
  - DATA_W and ADDR_W defaults.
  - State enum (IDLE, WAIT, DONE, HOLD).
  - Counter width constant (4 bits).
- Sub-module dm_array: synchronous single-port storage.
  - Ports: clk, we, re, addr, wdata, rdata.
  - One-edge write and registered read; no reset on contents.
  - dm_responder drives we/re only on the WAIT→DONE edge, which keeps the storage inferable as block RAM.
- FSM, counter and request latches stay in dm_responder.

Test Plan:
- Reset with ena=1 held: done=0, busy=0, douta=0 throughout reset. After release, a request is accepted on the first edge.
- LATENCY=2:
  - Write addr 0x05, data 0xDEADBEEF, ena held high: done pulses exactly 2 cycles after acceptance, for 1 cycle. busy stays high until ena drops.
  - Then a read of 0x05 returns douta=0xDEADBEEF together with done.
- ena held high for 10 cycles after done: exactly one access occurs (one done pulse, busy=1 in HOLD). After ena low→high, a second done follows.
- Change addra/dina during WAIT: write 0x11111111 to 0x10 accepted, then addra changed to 0x20 mid-wait. Only mem[0x10] is updated; a read of 0x20 returns its prior value.
- Assert rst=0 during WAIT of a write of 0xCAFEF00D to 0x7F: no done pulse. A later read of 0x7F returns the pre-reset contents, not 0xCAFEF00D.
- LATENCY=1 boundary, back-to-back write then read of 0x00 and 0x7F (ena toggled low one cycle between): done 1 cycle after each acceptance. Data round-trips correctly at both address extremes.
